ram_march_tester: RTL and testbench

RAM_MARCH_TESTER -- requirements
Module: ram_march_tester

---
 rtl/ram_march_tester.sv | 157 +++++++++++++++
 tb/tb_ram_march_tester.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_tester.sv
// ============================================================================
// ram_march_tester : up/down write-read march test for a distributed RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_march_tester #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [ADDR_WIDTH-1:0] last_address,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  ram_write_enabled,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_error_address,
  output logic [3:0]            task_phase
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] WRITE_UP   = 4'd1;
  localparam logic [3:0] READ_UP    = 4'd2;
  localparam logic [3:0] WRITE_DOWN = 4'd3;
  localparam logic [3:0] READ_DOWN  = 4'd4;
  localparam logic [3:0] DONE       = 4'd5;

  logic [3:0]            state;
  logic [3:0]            state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] last_reg;
  logic [DATA_WIDTH-1:0] seed_reg;
  logic [DATA_WIDTH-1:0] pattern;
  logic [DATA_WIDTH-1:0] expected;
  logic                  is_read;
  logic                  mismatch;
  logic                  at_last;
  logic                  at_base;
  logic                  range_ok;

  assign pattern     = seed_reg ^ DATA_WIDTH'(addr);
  assign expected    = (state == READ_DOWN) ? ~pattern : pattern;
  assign at_last     = (addr == last_reg);
  assign at_base     = (addr == base_reg);
  assign range_ok    = (base_reg <= last_reg);
  assign mismatch    = is_read && !abort && (ram_read_data != expected);
  assign ram_address = addr;
  assign task_phase  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = (base_address <= last_address) ? WRITE_UP : DONE;
      WRITE_UP:   if (abort) state_next = IDLE; else if (at_last) state_next = READ_UP;
      READ_UP:    if (abort) state_next = IDLE; else if (at_last) state_next = WRITE_DOWN;
      WRITE_DOWN: if (abort) state_next = IDLE; else if (at_base) state_next = READ_DOWN;
      READ_DOWN:  if (abort) state_next = IDLE; else if (at_base) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_write_enabled = 1'b0;
    ram_write_data    = '0;
    busy              = 1'b0;
    done              = 1'b0;
    is_read           = 1'b0;
    case (state)
      WRITE_UP: begin
        ram_write_enabled = 1'b1;
        ram_write_data    = pattern;
        busy              = 1'b1;
      end
      READ_UP: begin
        busy    = 1'b1;
        is_read = 1'b1;
      end
      WRITE_DOWN: begin
        ram_write_enabled = 1'b1;
        ram_write_data    = ~pattern;
        busy              = 1'b1;
      end
      READ_DOWN: begin
        busy    = 1'b1;
        is_read = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Address steps stop at the range ends so full-span ranges never wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr                <= '0;
      base_reg            <= '0;
      last_reg            <= '0;
      seed_reg            <= '0;
      error_count         <= '0;
      first_error_address <= '0;
      pass                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_reg            <= base_address;
            last_reg            <= last_address;
            seed_reg            <= seed;
            addr                <= base_address;
            error_count         <= '0;
            first_error_address <= '0;
            pass                <= 1'b0;
          end
        end
        WRITE_UP:   if (!abort) addr <= at_last ? base_reg : addr + ADDR_WIDTH'(1);
        READ_UP:    if (!abort && !at_last) addr <= addr + ADDR_WIDTH'(1);
        WRITE_DOWN: if (!abort) addr <= at_base ? last_reg : addr - ADDR_WIDTH'(1);
        READ_DOWN:  if (!abort && !at_base) addr <= addr - ADDR_WIDTH'(1);
        DONE:       pass <= range_ok && (error_count == 16'd0);
        default: ;
      endcase
      if (busy && abort) begin
        pass <= 1'b0;
      end
      if (mismatch) begin
        if (error_count != 16'hFFFF) begin
          error_count <= error_count + 16'd1;
        end
        if (error_count == 16'd0) begin
          first_error_address <= addr;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_march_tester.sv
// ============================================================================
// tb_ram_march_tester : directed self-checking bench with a behavioural RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ram_march_tester;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_address = '0;
  logic [15:0] last_address = '0;
  logic [31:0] seed = '0;
  logic        ram_write_enabled;
  logic [15:0] ram_address;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] error_count;
  logic [15:0] first_error_address;
  logic [3:0]  task_phase;

  logic [31:0] mem [0:65535];
  logic        stuck_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int busy_cyc, done_cnt, wr_cnt;
  int ph_cnt [0:15];
  logic [31:0] first_wd, last_wd;
  logic        mon_clear = 1'b0;

  ram_march_tester #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .start               (start),
    .abort               (abort),
    .base_address        (base_address),
    .last_address        (last_address),
    .seed                (seed),
    .ram_write_enabled   (ram_write_enabled),
    .ram_address         (ram_address),
    .ram_write_data      (ram_write_data),
    .ram_read_data       (ram_read_data),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .error_count         (error_count),
    .first_error_address (first_error_address),
    .task_phase          (task_phase)
  );

  always #5 clock = ~clock;

  // Address 0xF2 can be given a bit 0 stuck at 1.
  assign ram_read_data = mem[ram_address] |
                         ((stuck_en && ram_address == 16'h00F2) ? 32'h1 : 32'h0);

  always @(posedge clock) begin
    if (ram_write_enabled) mem[ram_address] <= ram_write_data;
  end

  always @(negedge clock) begin
    if (mon_clear) begin
      busy_cyc = 0;
      done_cnt = 0;
      wr_cnt   = 0;
      for (int i = 0; i < 16; i++) ph_cnt[i] = 0;
      mon_clear = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (ram_write_enabled) begin
        if (wr_cnt == 0) first_wd = ram_write_data;
        last_wd = ram_write_data;
        wr_cnt++;
      end
      ph_cnt[task_phase]++;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; clears monitor counters on that same edge.
  task automatic clear_mon();
    mon_clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] l, input logic [31:0] s);
    base_address = b;
    last_address = l;
    seed         = s;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
  endtask

  task automatic wait_phase(input logic [3:0] p, input int budget);
    int n = 0;
    while (task_phase != p && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_value("wait_phase_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (task_phase != 4'd0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_value("wait_idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_value({tag, "_phase"}, 32'(task_phase), 32'd0);
    check_value({tag, "_busy"}, 32'(busy), 32'd0);
    check_value({tag, "_done"}, 32'(done), 32'd0);
    check_value({tag, "_pass"}, 32'(pass), 32'd0);
    check_value({tag, "_errcnt"}, 32'(error_count), 32'd0);
    check_value({tag, "_feaddr"}, 32'(first_error_address), 32'd0);
    check_value({tag, "_addr"}, 32'(ram_address), 32'd0);
    check_value({tag, "_we"}, 32'(ram_write_enabled), 32'd0);
    check_value({tag, "_wdata"}, ram_write_data, 32'd0);
  endtask

  initial begin
    #1;
    check_zero_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Stuck-at-1 bit 0 at 0xF2: P(0xF2)=0x112233B6 fails up-read only.
    stuck_en = 1'b1;
    clear_mon();
    kick(16'h00F0, 16'h00F4, 32'h11223344);
    wait_idle(100);
    check_value("stuck_pass", 32'(pass), 32'd0);
    check_value("stuck_errcnt", 32'(error_count), 32'd1);
    check_value("stuck_feaddr", 32'(first_error_address), 32'h00F2);
    check_value("stuck_done", 32'(done_cnt), 32'd1);
    stuck_en = 1'b0;

    // Invalid range: DONE straight after start, counters cleared.
    clear_mon();
    kick(16'h0010, 16'h000F, 32'hDEADBEEF);
    check_value("inv_done_now", 32'(done), 32'd1);
    check_value("inv_phase_now", 32'(task_phase), 32'd5);
    wait_idle(10);
    check_value("inv_busy", 32'(busy_cyc), 32'd0);
    check_value("inv_writes", 32'(wr_cnt), 32'd0);
    check_value("inv_pass", 32'(pass), 32'd0);
    check_value("inv_errcnt", 32'(error_count), 32'd0);

    // Healthy RAM, 5 addresses.
    clear_mon();
    kick(16'h00F0, 16'h00F4, 32'h11223344);
    wait_idle(100);
    check_value("ok_busy", 32'(busy_cyc), 32'd20);
    check_value("ok_ph1", 32'(ph_cnt[1]), 32'd5);
    check_value("ok_ph2", 32'(ph_cnt[2]), 32'd5);
    check_value("ok_ph3", 32'(ph_cnt[3]), 32'd5);
    check_value("ok_ph4", 32'(ph_cnt[4]), 32'd5);
    check_value("ok_ph5", 32'(ph_cnt[5]), 32'd1);
    check_value("ok_done", 32'(done_cnt), 32'd1);
    check_value("ok_writes", 32'(wr_cnt), 32'd10);
    check_value("ok_pass", 32'(pass), 32'd1);
    check_value("ok_errcnt", 32'(error_count), 32'd0);
    check_value("ok_mem_f2", mem[16'h00F2], 32'hEEDDCC49);
    check_value("ok_mem_f0", mem[16'h00F0], 32'hEEDDCC4B);

    // Single address at 0.
    clear_mon();
    kick(16'h0000, 16'h0000, 32'hA5A50F0F);
    wait_idle(20);
    check_value("one_busy", 32'(busy_cyc), 32'd4);
    check_value("one_writes", 32'(wr_cnt), 32'd2);
    check_value("one_wd_first", first_wd, 32'hA5A50F0F);
    check_value("one_wd_last", last_wd, 32'h5A5AF0F0);
    check_value("one_pass", 32'(pass), 32'd1);

    // Top of the address space: no increment past 0xFFFF.
    clear_mon();
    kick(16'hFFFC, 16'hFFFF, 32'h0F0F0F0F);
    wait_idle(40);
    check_value("top_busy", 32'(busy_cyc), 32'd16);
    check_value("top_ph2", 32'(ph_cnt[2]), 32'd4);
    check_value("top_pass", 32'(pass), 32'd1);
    check_value("top_mem_ffff", mem[16'hFFFF], 32'hF0F00F0F);

    // Bottom of the address space: no decrement below 0.
    clear_mon();
    kick(16'h0000, 16'h0003, 32'h00000000);
    wait_idle(40);
    check_value("bot_busy", 32'(busy_cyc), 32'd16);
    check_value("bot_ph4", 32'(ph_cnt[4]), 32'd4);
    check_value("bot_pass", 32'(pass), 32'd1);

    // Abort during READ_UP.
    clear_mon();
    kick(16'h00F0, 16'h00F4, 32'h11223344);
    wait_phase(4'd2, 20);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_value("abort_phase", 32'(task_phase), 32'd0);
    check_value("abort_we", 32'(ram_write_enabled), 32'd0);
    check_value("abort_pass", 32'(pass), 32'd0);
    @(negedge clock);
    check_value("abort_no_done", 32'(done_cnt), 32'd0);

    // Rerun; a start pulse mid-test must not disturb it.
    clear_mon();
    kick(16'h00F0, 16'h00F4, 32'h11223344);
    wait_phase(4'd2, 20);
    base_address = 16'h0000;
    last_address = 16'h0000;
    seed         = 32'h0;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
    wait_idle(100);
    check_value("rerun_busy", 32'(busy_cyc), 32'd20);
    check_value("rerun_pass", 32'(pass), 32'd1);
    check_value("rerun_mem_f4", mem[16'h00F4], 32'hEEDDCC4F);

    // Asynchronous reset during WRITE_DOWN.
    clear_mon();
    kick(16'h00F0, 16'h00F4, 32'h11223344);
    wait_phase(4'd3, 40);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clock);
    check_value("midrst_no_done", 32'(done_cnt), 32'd0);
    reset_n = 1'b1;
    clear_mon();
    kick(16'h00F0, 16'h00F4, 32'h11223344);
    check_value("postrst_phase", 32'(task_phase), 32'd1);
    wait_idle(100);
    check_value("postrst_busy", 32'(busy_cyc), 32'd20);
    check_value("postrst_done", 32'(done_cnt), 32'd1);
    check_value("postrst_pass", 32'(pass), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
